// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Loads a checksummed big-endian program image from the UART byte
//            stream into IMEM and releases the CPU reset once it verifies.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int          ADDR_W       = 10,
    parameter int          GAP_TIMEOUT  = 1000000,
    parameter logic [31:0] RELOAD_MAGIC = 32'hB007_10AD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int                 c_GAP_W     = $clog2(GAP_TIMEOUT + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [32:0]        c_MAX_WORDS = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_WAIT_HDR = 3'd0,
        S_LOAD     = 3'd1,
        S_CHECK    = 3'd2,
        S_RUN      = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_shift;
    logic [31:0]         r_word;
    logic                r_word_valid;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [ADDR_W:0]     r_num_words;
    logic [ADDR_W:0]     r_word_count;
    logic [31:0]         r_sum;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [31:0]         r_imem_wdata;
    logic                r_cpu_rst_n;
    logic                r_load_busy;
    logic                r_load_done;
    logic                r_load_err;

    logic                w_gap_expire;
    logic                w_hdr_ok;
    logic                w_load_word;
    logic [ADDR_W:0]     w_count_inc;

    // A byte arriving in the expiry cycle clears the counter instead.
    assign w_gap_expire = !rx_valid && (r_byte_idx != 2'd0) && (r_gap_cnt == c_GAP_LAST);
    assign w_hdr_ok     = (r_word != 32'd0) && ({1'b0, r_word} <= c_MAX_WORDS);
    assign w_load_word  = (r_state == S_LOAD) && r_word_valid;
    assign w_count_inc  = r_word_count + (ADDR_W+1)'(1);

    // Byte-to-word assembler with inter-byte gap supervision
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_byte_idx   <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_word_valid <= 1'b0;
            if (rx_valid) begin
                r_gap_cnt  <= '0;
                r_byte_idx <= r_byte_idx + 2'd1;
                r_shift    <= {r_shift[15:0], rx_data};
                if (r_byte_idx == 2'd3) begin
                    r_word       <= {r_shift, rx_data};
                    r_word_valid <= 1'b1;
                end
            end else if (r_byte_idx != 2'd0) begin
                if (w_gap_expire) begin
                    r_byte_idx <= 2'd0;
                    r_gap_cnt  <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_HDR: begin
                if (r_word_valid) begin
                    w_next = w_hdr_ok ? S_LOAD : S_ERROR;
                end
            end
            S_LOAD: begin
                if (w_gap_expire) begin
                    w_next = S_ERROR;
                end else if (r_word_valid && (w_count_inc == r_num_words)) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_gap_expire) begin
                    w_next = S_ERROR;
                end else if (r_word_valid) begin
                    w_next = (r_word == r_sum) ? S_RUN : S_ERROR;
                end
            end
            S_RUN, S_ERROR: begin
                if (r_word_valid && (r_word == RELOAD_MAGIC)) begin
                    w_next = S_WAIT_HDR;
                end
            end
            default: w_next = S_WAIT_HDR;
        endcase
    end

    // State, write port and status registers; status follows the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_WAIT_HDR;
            r_num_words  <= '0;
            r_word_count <= '0;
            r_sum        <= 32'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_cpu_rst_n  <= 1'b0;
            r_load_busy  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_imem_we <= w_load_word;
            if ((r_state == S_WAIT_HDR) && r_word_valid && w_hdr_ok) begin
                r_num_words  <= r_word[ADDR_W:0];
                r_word_count <= '0;
                r_sum        <= 32'd0;
            end
            if (w_load_word) begin
                r_imem_addr  <= r_word_count[ADDR_W-1:0];
                r_imem_wdata <= r_word;
                r_sum        <= r_sum + r_word;
                r_word_count <= w_count_inc;
            end
            r_cpu_rst_n <= (w_next == S_RUN);
            r_load_done <= (w_next == S_RUN);
            r_load_err  <= (w_next == S_ERROR);
            r_load_busy <= (w_next == S_LOAD) || (w_next == S_CHECK);
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign load_busy  = r_load_busy;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Scoreboard bench for imem_boot_loader against an image-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int          ADDR_W = 10;
    localparam int          GAP    = 40;
    localparam logic [31:0] MAGIC  = 32'hB007_10AD;

    localparam int M_WAIT = 0, M_LOAD = 1, M_CHECK = 2, M_RUN = 3, M_ERR = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n, load_busy, load_done, load_err;
    logic [ADDR_W:0]   word_count;

    imem_boot_loader #(.ADDR_W(ADDR_W), .GAP_TIMEOUT(GAP), .RELOAD_MAGIC(MAGIC)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int t; logic [3:0] st; } st_t;
    wr_t wq[$];
    st_t sq[$];

    int n_cmp = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model state: image-level view of the loader
    int          m_state = M_WAIT;
    logic [7:0]  m_bytes[$];
    int          m_idle = 0;
    longint      m_n = 0;
    logic [31:0] m_sum = 0;
    int          m_cnt = 0;
    logic [3:0]  m_stat = 4'b0000;
    logic [ADDR_W-1:0] m_last_addr = '0;
    logic [31:0] m_last_data = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {load_busy, load_done, load_err, cpu_rst_n} for each model state
    function automatic logic [3:0] stat_of(input int s);
        case (s)
            M_LOAD, M_CHECK: return 4'b1000;
            M_RUN:           return 4'b0101;
            M_ERR:           return 4'b0010;
            default:         return 4'b0000;
        endcase
    endfunction

    task automatic m_goto(input int s, input int t);
        m_state = s;
        if (stat_of(s) != m_stat) begin
            m_stat = stat_of(s);
            sq.push_back('{t: t, st: m_stat});
        end
    endtask

    task automatic m_word(input logic [31:0] w, input int t);
        case (m_state)
            M_WAIT: begin
                if (w == 32'd0 || longint'(w) > (longint'(1) << ADDR_W)) m_goto(M_ERR, t);
                else begin
                    m_n = longint'(w); m_sum = 0; m_cnt = 0;
                    m_goto(M_LOAD, t);
                end
            end
            M_LOAD: begin
                wq.push_back('{t: t, addr: ADDR_W'(m_cnt), data: w});
                m_last_addr = ADDR_W'(m_cnt);
                m_last_data = w;
                m_sum = m_sum + w;
                m_cnt++;
                if (m_cnt == m_n) m_goto(M_CHECK, t);
            end
            M_CHECK: m_goto((w == m_sum) ? M_RUN : M_ERR, t);
            default: if (w == MAGIC) m_goto(M_WAIT, t);
        endcase
    endtask

    task automatic drive(input bit v, input logic [7:0] d);
        logic [31:0] w;
        @(posedge clk); #1;
        rx_valid = v;
        rx_data  = d;
        if (v) begin
            m_bytes.push_back(d);
            m_idle = 0;
            if (m_bytes.size() == 4) begin
                w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_bytes.delete();
                m_word(w, cyc + 2);
            end
        end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == GAP) begin
                m_bytes.delete();
                m_idle = 0;
                if (m_state == M_LOAD || m_state == M_CHECK) m_goto(M_ERR, cyc + 1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, w[31-8*b -: 8]);
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic send_image(input int n, input bit good, input int gap);
        logic [31:0] s, w;
        s = 32'd0;
        send_word(32'(n), gap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            s = s + w;
            send_word(w, gap);
        end
        send_word(good ? s : s + 32'(1 + $urandom_range(0, 99)), gap);
    endtask

    task automatic do_reset();
        idle(3);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        m_bytes.delete();
        m_idle = 0;
        m_state = M_WAIT;
        m_cnt = 0;
        m_sum = 0;
        m_last_addr = '0;
        m_last_data = 32'd0;
        if (m_stat != 4'b0000) sq.push_back('{t: cyc + 1, st: 4'b0000});
        m_stat = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic settle_check(input string tag);
        idle(4);
        check({tag, "_status"}, {load_busy, load_done, load_err, cpu_rst_n}, stat_of(m_state));
        check({tag, "_word_count"}, word_count, m_cnt);
        check({tag, "_addr_hold"}, imem_addr, m_last_addr);
        check({tag, "_wdata_hold"}, imem_wdata, m_last_data);
    endtask

    // Monitor: consumes expected writes and status changes as the DUT shows them
    logic [3:0] prev_st = 4'b0000;
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_imem_we", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_wdata, e.data);
                    check("wr_cycle", cyc, e.t);
                end
            end
            if ({load_busy, load_done, load_err, cpu_rst_n} !== prev_st) begin
                prev_st = {load_busy, load_done, load_err, cpu_rst_n};
                if (sq.size() == 0) begin
                    check("unexpected_status", prev_st, m_stat);
                end else begin
                    st_t s;
                    s = sq.pop_front();
                    check("status_value", prev_st, s.st);
                    check("status_cycle", cyc, s.t);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_load_busy", load_busy, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic three-word image
        send_word(32'h0000_0003, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        send_word(32'h3333_3333, 0);
        send_word(32'h6666_6666, 0);
        settle_check("img3");
        check("img3_done", load_done, 1);

        // Bad checksum, then reload
        send_word(MAGIC, 0);
        send_word(32'h0000_0003, 0);
        send_word(32'h1111_1111, 0);
        send_word(32'h2222_2222, 0);
        send_word(32'h3333_3333, 0);
        send_word(32'h6666_6667, 0);
        settle_check("badsum");
        check("badsum_err", load_err, 1);
        send_word(MAGIC, 1);
        send_image(3, 1'b1, 1);
        settle_check("reload");

        // Header limits
        send_word(MAGIC, 0);
        send_word(32'h0000_0000, 0);
        settle_check("hdr0");
        send_word(MAGIC, 0);
        send_word(32'h0000_0401, 0);
        settle_check("hdr401");
        send_word(MAGIC, 0);
        send_word(32'h0000_0400, 0);
        settle_check("hdr400");
        check("hdr400_busy", load_busy, 1);
        do_reset();

        // Gap one short of timeout is tolerated
        send_word(32'h0000_0002, 0);
        send_word(32'hA5A5_0001, 0);
        drive(1'b1, 8'h12); drive(1'b1, 8'h34);
        idle(GAP - 1);
        drive(1'b1, 8'h56); drive(1'b1, 8'h78);
        send_word(32'hA5A5_0001 + 32'h1234_5678, 0);
        settle_check("gap_short");

        // Full gap in LOAD aborts with an error
        send_word(MAGIC, 0);
        send_word(32'h0000_0003, 0);
        send_word(32'hCAFE_0000, 0);
        drive(1'b1, 8'hAB); drive(1'b1, 8'hCD);
        idle(GAP);
        settle_check("gap_load");
        check("gap_load_err", load_err, 1);

        // Full gap in WAIT_HDR only drops the partial bytes
        send_word(MAGIC, 0);
        drive(1'b1, 8'h00); drive(1'b1, 8'h00);
        idle(GAP);
        send_image(2, 1'b1, 0);
        settle_check("gap_wait");

        // Checksum wrap, ignored word in RUN, then reload magic
        send_word(MAGIC, 0);
        send_word(32'h0000_0002, 0);
        send_word(32'hFFFF_FFFF, 0);
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0001, 0);
        settle_check("wrap");
        send_word(32'hDEAD_BEEF, 0);
        settle_check("run_ignore");
        send_word(MAGIC, 0);
        settle_check("run_magic");

        // Reset mid-load
        send_word(32'h0000_0004, 0);
        send_word(32'h0101_0101, 0);
        send_word(32'h0202_0202, 0);
        do_reset();
        settle_check("midrst");
        send_image(4, 1'b1, 2);
        settle_check("after_rst");

        // Randomised images
        for (int it = 0; it < 30; it++) begin
            if (m_state == M_RUN || m_state == M_ERR) send_word(MAGIC, $urandom_range(0, 2));
            else if (m_state != M_WAIT) do_reset();
            send_image($urandom_range(1, 6), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) send_word($urandom, 1);
            settle_check("rand");
        end

        idle(10);
        check("wr_queue_empty", wq.size(), 0);
        check("status_queue_empty", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
